// File: rtl/sapx_core.sv
// SAP-x core: internal RAM, accumulator/B datapath, multi-cycle T-state sequencer and OUT port.
// Optional SAPX_CYCLE_CNT_EN adds cycle_cnt_o, a free-running count of non-HALT cycles.
module sapx_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [1:0]        flags_o,
  output logic              halted_o
`ifdef SAPX_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt_o
`endif
);
  typedef enum logic [2:0] {S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4} state_t;
  localparam logic [3:0] OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_STA = 4'h3,
                         OP_LDI = 4'h4, OP_JMP = 4'h5, OP_JC  = 4'h6, OP_JZ  = 4'h7,
                         OP_OUT = 4'he, OP_HLT = 4'hf;

  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] b_reg, ir, mem_rd;
  logic [ADDR_W-1:0] mar, opnd;
  logic [3:0]        opcode;
  logic [DATA_W:0]   alu_sum;
  logic              c_flag, z_flag, out_stall;

  assign opcode    = ir[DATA_W-1 -: 4];
  assign opnd      = ir[ADDR_W-1:0];
  assign mem_rd    = mem[mar];
  assign flags_o   = {c_flag, z_flag};
  assign halted_o  = (state == S_HALT);
  assign out_stall = out_valid_o && !out_ready_i;

  // SUB is acc + ~B + 1, so carry out means "no borrow".
  always_comb begin
    alu_sum = {1'b0, acc_o} + {1'b0, b_reg};
    if (opcode == OP_SUB)
      alu_sum = {1'b0, acc_o} + {1'b0, ~b_reg} + (DATA_W+1)'(1);
  end

  // RAM has no reset; reset only blocks a write in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == S_HALT && prog_we_i)
        mem[prog_addr_i] <= prog_data_i;
      else if (state == S_T3 && opcode == OP_STA)
        mem[mar] <= acc_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_HALT;
      pc_o        <= '0;
      acc_o       <= '0;
      b_reg       <= '0;
      ir          <= '0;
      mar         <= '0;
      c_flag      <= 1'b0;
      z_flag      <= 1'b0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i)
        out_valid_o <= 1'b0;
      case (state)
        S_HALT: if (run_i) state <= S_T0;
        S_T0: begin
          mar   <= pc_o;
          state <= S_T1;
        end
        S_T1: begin
          ir    <= mem_rd;
          pc_o  <= pc_o + ADDR_W'(1);
          state <= S_T2;
        end
        S_T2: begin
          state <= S_T0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar   <= opnd;
              state <= S_T3;
            end
            OP_LDI: acc_o <= {{(DATA_W-ADDR_W){1'b0}}, opnd};
            OP_JMP: pc_o  <= opnd;
            OP_JC:  if (c_flag) pc_o <= opnd;
            OP_JZ:  if (z_flag) pc_o <= opnd;
            OP_OUT: begin
              if (out_stall) begin
                state <= S_T2;
              end else begin
                out_data_o  <= acc_o;
                out_valid_o <= 1'b1;
              end
            end
            OP_HLT:  state <= S_HALT;
            default: ;
          endcase
        end
        S_T3: begin
          state <= S_T0;
          case (opcode)
            OP_LDA:         acc_o <= mem_rd;
            OP_ADD, OP_SUB: begin
              b_reg <= mem_rd;
              state <= S_T4;
            end
            default: ;
          endcase
        end
        S_T4: begin
          {c_flag, acc_o} <= alu_sum;
          z_flag          <= (alu_sum[DATA_W-1:0] == '0);
          state           <= S_T0;
        end
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef SAPX_CYCLE_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                 cycle_cnt_o <= '0;
    else if (state != S_HALT)  cycle_cnt_o <= cycle_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_sapx_core.sv
// Directed and randomized checks of sapx_core against an instruction-level reference model.
module tb_sapx_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1, run = 1'b0, we = 1'b0, ready = 1'b1;
  logic [3:0] paddr = '0, pc;
  logic [7:0] pdata = '0, odata, acc;
  logic [1:0] flags;
  logic       ovalid, halted;
`ifdef SAPX_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;
`endif

  always #5 clk = ~clk;

  sapx_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .prog_we_i(we), .prog_addr_i(paddr),
    .prog_data_i(pdata), .out_ready_i(ready), .out_valid_o(ovalid), .out_data_o(odata),
    .pc_o(pc), .acc_o(acc), .flags_o(flags), .halted_o(halted)
`ifdef SAPX_CYCLE_CNT_EN
    , .cycle_cnt_o(cyc_cnt)
`endif
  );

  int ncmp = 0, nerr = 0;
  logic [7:0] outq [$];

  // Every accepted output beat, sampled mid-cycle where inputs and outputs are stable.
  always @(negedge clk) if (ovalid === 1'b1 && ready === 1'b1) outq.push_back(odata);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(); @(posedge clk); #1; endtask

  task automatic do_reset(); rst = 1'b1; step(); rst = 1'b0; endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic r);
    we = 1'b1; paddr = a; pdata = d; run = r;
    step();
    we = 1'b0; run = 1'b0;
  endtask

  task automatic run_prog(input bit pulse, output int cyc);
    if (pulse) begin run = 1'b1; step(); run = 1'b0; end
    cyc = 0;
    while (halted !== 1'b1 && cyc < 3000) begin step(); cyc++; end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  // Reference model: executes whole instructions, counting cycles per opcode.
  logic [7:0] prog [16];
  logic [7:0] m_mem [16];
  logic [7:0] m_acc;
  logic [3:0] m_pc;
  logic       m_c, m_z;
  int         m_cyc;
  logic [7:0] m_outs [$];

  task automatic model_run(output bit ok);
    logic [7:0] w, v;
    logic [3:0] a;
    int s;
    m_acc = 0; m_c = 0; m_z = 0; m_pc = 0; m_cyc = 0; m_outs.delete(); ok = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = prog[i];
    for (int n = 0; n < 40 && !ok; n++) begin
      w = m_mem[m_pc]; m_pc = m_pc + 4'd1; a = w[3:0]; v = m_mem[a];
      case (w[7:4])
        4'h0: begin m_acc = v; m_cyc += 4; end
        4'h1: begin
          s = int'(m_acc) + int'(v); m_c = (s > 255); m_acc = 8'(s); m_z = (m_acc == 0); m_cyc += 5;
        end
        4'h2: begin m_c = (m_acc >= v); m_acc = m_acc - v; m_z = (m_acc == 0); m_cyc += 5; end
        4'h3: begin m_mem[a] = m_acc; m_cyc += 4; end
        4'h4: begin m_acc = {4'h0, a}; m_cyc += 3; end
        4'h5: begin m_pc = a; m_cyc += 3; end
        4'h6: begin if (m_c) m_pc = a; m_cyc += 3; end
        4'h7: begin if (m_z) m_pc = a; m_cyc += 3; end
        4'he: begin m_outs.push_back(m_acc); m_cyc += 3; end
        4'hf: begin m_cyc += 3; ok = 1; end
        default: m_cyc += 3;
      endcase
    end
  endtask

  initial begin
    int cyc;
    bit ok;
    logic [3:0] opl [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'he, 4'hf};

    step(); step(); rst = 1'b0;
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_pc", {28'd0, pc}, 32'd0);
    chk("rst_acc", {24'd0, acc}, 32'd0);
    chk("rst_valid", {31'd0, ovalid}, 32'd0);
    chk("rst_flags", {30'd0, flags}, 32'd0);

    // Basic program; last write shares its cycle with run.
    wr(4'h0, 8'h09, 0); wr(4'h1, 8'h1a, 0); wr(4'h2, 8'he0, 0); wr(4'h3, 8'hf0, 0);
    wr(4'h9, 8'h05, 0); outq.delete(); wr(4'ha, 8'h03, 1);
    run_prog(0, cyc);
    chk("basic_nout", outq.size(), 32'd1);
    chk("basic_out", {24'd0, outq[0]}, 32'h08);
    chk("basic_pc", {28'd0, pc}, 32'd4);
    chk("basic_cycles", cyc, 32'd15);
`ifdef SAPX_CYCLE_CNT_EN
    chk("basic_cnt", cyc_cnt, 32'd15);
`endif

    // Write attempt while running must be ignored.
    do_reset();
    wr(4'h0, 8'h09, 0); wr(4'h1, 8'he0, 0); wr(4'h2, 8'hf0, 0); outq.delete(); wr(4'h9, 8'h11, 1);
    we = 1'b1; paddr = 4'h9; pdata = 8'h77; step(); we = 1'b0;
    run_prog(0, cyc);
    chk("we_ignored", {24'd0, outq[0]}, 32'h11);

    // Output back-pressure: second OUT stalls until the consumer is ready.
    do_reset(); ready = 1'b0; outq.delete();
    wr(4'h0, 8'h45, 0); wr(4'h1, 8'he0, 0); wr(4'h2, 8'h46, 0); wr(4'h3, 8'he0, 0); wr(4'h4, 8'hf0, 1);
    repeat (25) step();
    chk("stall_running", {31'd0, halted}, 32'd0);
    chk("stall_valid", {31'd0, ovalid}, 32'd1);
    chk("stall_data", {24'd0, odata}, 32'h05);
    chk("stall_pc", {28'd0, pc}, 32'd4);
    ready = 1'b1; step();
    chk("reload_valid", {31'd0, ovalid}, 32'd1);
    chk("reload_data", {24'd0, odata}, 32'h06);
    chk("reload_first", {24'd0, outq[0]}, 32'h05);
    run_prog(0, cyc);
    chk("stall_nout", outq.size(), 32'd2);
    chk("stall_second", {24'd0, outq[1]}, 32'h06);

    // Reset during STA T3 blocks the RAM write.
    do_reset();
    wr(4'h0, 8'h47, 0); wr(4'h1, 8'h39, 0); wr(4'h2, 8'hf0, 0); wr(4'h9, 8'h22, 0);
    run = 1'b1; step(); run = 1'b0;
    repeat (6) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("sta_rst_halted", {31'd0, halted}, 32'd1);
    chk("sta_rst_pc", {28'd0, pc}, 32'd0);
    chk("sta_rst_acc", {24'd0, acc}, 32'd0);
    chk("sta_rst_data", {24'd0, odata}, 32'd0);
    chk("sta_rst_flags", {30'd0, flags}, 32'd0);
`ifdef SAPX_CYCLE_CNT_EN
    chk("sta_rst_cnt", cyc_cnt, 32'd0);
`endif
    wr(4'h0, 8'h09, 0); wr(4'h1, 8'he0, 0); outq.delete(); wr(4'h2, 8'hf0, 1);
    run_prog(0, cyc);
    chk("sta_no_write", {24'd0, outq[0]}, 32'h22);

    // Carry/zero: FF+01 and 02-03.
    do_reset();
    wr(4'h0, 8'h09, 0); wr(4'h1, 8'h1a, 0); wr(4'h2, 8'hf0, 0); wr(4'h9, 8'hff, 0); wr(4'ha, 8'h01, 1);
    run_prog(0, cyc);
    chk("add_acc", {24'd0, acc}, 32'h00);
    chk("add_flags", {30'd0, flags}, 32'd3);
    wr(4'h1, 8'h2a, 0); wr(4'h9, 8'h02, 0); wr(4'ha, 8'h03, 0);
    do_reset(); run_prog(1, cyc);
    chk("sub_borrow_acc", {24'd0, acc}, 32'hff);
    chk("sub_borrow_flags", {30'd0, flags}, 32'd0);

    // SUB to zero, then JZ taken to C.
    do_reset();
    wr(4'h0, 8'h09, 0); wr(4'h1, 8'h2a, 0); wr(4'h2, 8'h7c, 0); wr(4'h3, 8'h41, 0); wr(4'h4, 8'hf0, 0);
    wr(4'hc, 8'hf0, 0); wr(4'h9, 8'h03, 0); wr(4'ha, 8'h03, 1);
    run_prog(0, cyc);
    chk("jz_pc", {28'd0, pc}, 32'hd);
    chk("jz_acc", {24'd0, acc}, 32'h00);
    chk("jz_flags", {30'd0, flags}, 32'd3);

    // PC wrap: JMP F then NOP at F.
    do_reset();
    wr(4'h0, 8'h5f, 0); wr(4'hf, 8'h80, 1);
    repeat (5) step();
    chk("wrap_pc", {28'd0, pc}, 32'd0);
    chk("wrap_running", {31'd0, halted}, 32'd0);

    // Randomized programs against the reference model.
    for (int t = 0; t < 20; t++) begin
      ok = 0;
      for (int att = 0; att < 500 && !ok; att++) begin
        for (int i = 0; i < 16; i++)
          prog[i] = {opl[$urandom_range(0, 10)], 4'($urandom)};
        model_run(ok);
      end
      do_reset();
      for (int i = 0; i < 16; i++) wr(4'(i), prog[i], 0);
      outq.delete();
      run_prog(1, cyc);
      chk("rnd_acc", {24'd0, acc}, {24'd0, m_acc});
      chk("rnd_flags", {30'd0, flags}, {30'd0, m_c, m_z});
      chk("rnd_pc", {28'd0, pc}, {28'd0, m_pc});
      chk("rnd_cycles", cyc, m_cyc);
      chk("rnd_nout", outq.size(), m_outs.size());
      for (int k = 0; k < m_outs.size() && k < outq.size(); k++)
        chk("rnd_out", {24'd0, outq[k]}, {24'd0, m_outs[k]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
